// File: rtl/pkt_pkg.sv
// pkt_pkg: definitions shared by the action executor and its FIFO.
//   - opcodes carried in action[15:12]
//   - bit positions of the action fields (opcode, egress port, byte index)
//   - egress port width
package pkt_pkg;

  localparam int PORT_W = 4;

  localparam logic [3:0] OP_FWD  = 4'h0;
  localparam logic [3:0] OP_DROP = 4'h1;
  localparam logic [3:0] OP_SETB = 4'h2;
  localparam logic [3:0] OP_INCB = 4'h3;

  // action word layout: [15:12] opcode, [11:8] port, [7:6] unused, [5:0] byte index
  localparam int ACT_OP_LSB   = 12;
  localparam int ACT_OP_W     = 4;
  localparam int ACT_PORT_LSB = 8;
  localparam int ACT_IDX_LSB  = 0;
  localparam int ACT_IDX_W    = 6;

endpackage

// File: rtl/action_exec_if.sv
// action_exec_if: packet bus around the action executor.
//   Upstream side : pkt_vld_in, pkt_data_in, action_in, state_in (no ready)
//   Downstream    : pkt_vld_out, pkt_data_out, pkt_port_out, pkt_rdy_in
//   master = the environment (drives inputs, accepts outputs)
//   slave  = action_exec
interface action_exec_if #(
  parameter int DATA_W = 512
);
  import pkt_pkg::*;

  logic              pkt_vld_in;
  logic [DATA_W-1:0] pkt_data_in;
  logic [15:0]       action_in;
  logic [7:0]        state_in;
  logic              pkt_vld_out;
  logic [DATA_W-1:0] pkt_data_out;
  logic [PORT_W-1:0] pkt_port_out;
  logic              pkt_rdy_in;

  modport master (
    output pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
    input  pkt_vld_out, pkt_data_out, pkt_port_out
  );

  modport slave (
    input  pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
    output pkt_vld_out, pkt_data_out, pkt_port_out
  );

endinterface

// File: rtl/pkt_fifo.sv
// pkt_fifo: synchronous first-word-fall-through FIFO.
//   push/din  : write when push=1 and (not full, or a pop happens in the same cycle)
//   pop/dout  : dout shows the head while !empty; pop advances it
//   full/empty/count : occupancy status
// While empty, dout keeps the last entry popped (0 after reset).
module pkt_fifo #(
  parameter int WIDTH = 516,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: storage has no reset; pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/action_exec.sv
// action_exec: applies a 16-bit action to each packet vector and queues survivors.
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : packet in (strobe, data, action, state) / packet out (FWFT with ready)
//   drop_cnt    : packets discarded by DROP or an illegal action
//   bad_op_cnt  : packets with an illegal opcode or byte index
//   ovf_cnt     : packets lost because the output FIFO was full
// Stage 1 registers the modified packet; stage 2 pushes it into the FIFO.
module action_exec
  import pkt_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  action_exec_if.slave     bus,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] bad_op_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int NBYTES = DATA_W / 8;
  localparam int FW     = DATA_W + PORT_W;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [ACT_OP_W-1:0]  op;
  logic [PORT_W-1:0]    port;
  logic [ACT_IDX_W-1:0] idx;
  logic                 op_ok, idx_ok, keep, bad;
  logic [DATA_W-1:0]    mod_data;

  logic              s1_vld_q, s1_vld_d;
  logic              s1_keep_q, s1_keep_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [PORT_W-1:0] s1_port_q, s1_port_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  bad_op_cnt_q, bad_op_cnt_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    return (ev && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign op     = bus.action_in[ACT_OP_LSB +: ACT_OP_W];
  assign port   = bus.action_in[ACT_PORT_LSB +: PORT_W];
  assign idx    = bus.action_in[ACT_IDX_LSB +: ACT_IDX_W];
  assign op_ok  = (op <= OP_INCB);
  assign idx_ok = (32'(idx) < 32'(NBYTES));
  assign keep   = op_ok && idx_ok && (op != OP_DROP);
  assign bad    = !op_ok || !idx_ok;

  // Reserved action bits and FIFO occupancy are not needed by this stage.
  assign unused_bits = ^{bus.action_in[7:6], fifo_count};

  // Only the addressed byte changes; INCB wraps inside the byte.
  always_comb begin
    mod_data = bus.pkt_data_in;
    for (int k = 0; k < NBYTES; k++) begin
      if (32'(idx) == 32'(k)) begin
        case (op)
          OP_SETB: mod_data[8*k +: 8] = bus.state_in;
          OP_INCB: mod_data[8*k +: 8] = bus.pkt_data_in[8*k +: 8] + 8'd1;
          default: mod_data[8*k +: 8] = bus.pkt_data_in[8*k +: 8];
        endcase
      end
    end
  end

  assign fifo_push = s1_vld_q & s1_keep_q;
  assign fifo_pop  = bus.pkt_vld_out & bus.pkt_rdy_in;

  always_comb begin
    s1_vld_d     = bus.pkt_vld_in;
    s1_keep_d    = s1_keep_q;
    s1_data_d    = s1_data_q;
    s1_port_d    = s1_port_q;
    if (bus.pkt_vld_in) begin
      s1_keep_d = keep;
      s1_data_d = mod_data;
      s1_port_d = port;
    end
    drop_cnt_d   = sat_inc(drop_cnt_q,   bus.pkt_vld_in & ~keep);
    bad_op_cnt_d = sat_inc(bad_op_cnt_q, bus.pkt_vld_in & bad);
    ovf_cnt_d    = sat_inc(ovf_cnt_q,    fifo_push & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q     <= 1'b0;
      s1_keep_q    <= 1'b0;
      s1_data_q    <= '0;
      s1_port_q    <= '0;
      drop_cnt_q   <= '0;
      bad_op_cnt_q <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_keep_q    <= s1_keep_d;
      s1_data_q    <= s1_data_d;
      s1_port_q    <= s1_port_d;
      drop_cnt_q   <= drop_cnt_d;
      bad_op_cnt_q <= bad_op_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  pkt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({s1_port_q, s1_data_q}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.pkt_vld_out  = ~fifo_empty;
  assign bus.pkt_data_out = fifo_dout[DATA_W-1:0];
  assign bus.pkt_port_out = fifo_dout[FW-1 -: PORT_W];
  assign drop_cnt         = drop_cnt_q;
  assign bad_op_cnt       = bad_op_cnt_q;
  assign ovf_cnt          = ovf_cnt_q;

endmodule

// File: tb/tb_action_exec.sv
// Directed bench for action_exec: FWD/SETB/INCB, drops, overflow, full push+pop, async reset.
module tb_action_exec;
  import pkt_pkg::*;

  localparam int DATA_W = 512;
  localparam int CNT_W  = 16;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] drop_cnt, bad_op_cnt, ovf_cnt;
  int               n_total = 0;
  int               n_bad   = 0;

  action_exec_if #(.DATA_W(DATA_W)) bus ();

  action_exec #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .drop_cnt   (drop_cnt),
    .bad_op_cnt (bad_op_cnt),
    .ovf_cnt    (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle input strobe.
  task automatic send(input logic [511:0] d, input logic [15:0] a, input logic [7:0] s);
    bus.pkt_vld_in  = 1'b1;
    bus.pkt_data_in = d;
    bus.action_in   = a;
    bus.state_in    = s;
    tick();
    bus.pkt_vld_in  = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.pkt_vld_in  = 1'b0;
    bus.pkt_data_in = '0;
    bus.action_in   = '0;
    bus.state_in    = '0;
    bus.pkt_rdy_in  = 1'b0;

    #2;
    check("rst_vld",  512'(bus.pkt_vld_out),  512'(0));
    check("rst_data", bus.pkt_data_out,       512'(0));
    check("rst_port", 512'(bus.pkt_port_out), 512'(0));
    check("rst_drop", 512'(drop_cnt),         512'(0));
    check("rst_bad",  512'(bad_op_cnt),       512'(0));
    check("rst_ovf",  512'(ovf_cnt),          512'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();

    // FWD: visible two edges after the strobe, then popped.
    bus.pkt_rdy_in = 1'b1;
    send(512'h4329, 16'h0300, 8'h00);
    check("fwd_vld_early", 512'(bus.pkt_vld_out), 512'(0));
    tick();
    check("fwd_vld",  512'(bus.pkt_vld_out),  512'(1));
    check("fwd_data", bus.pkt_data_out,       512'h4329);
    check("fwd_port", 512'(bus.pkt_port_out), 512'(3));
    tick();
    check("fwd_popped", 512'(bus.pkt_vld_out), 512'(0));
    check("fwd_hold",   bus.pkt_data_out,      512'h4329);

    // SETB byte 1 := A5.
    send(512'h4329, 16'h2501, 8'hA5);
    tick();
    check("setb_vld",  512'(bus.pkt_vld_out),  512'(1));
    check("setb_data", bus.pkt_data_out,       512'hA529);
    check("setb_port", 512'(bus.pkt_port_out), 512'(5));
    tick();

    // INCB byte 1 wraps FF -> 00 without touching byte 2.
    send(512'hFF29, 16'h3101, 8'h00);
    tick();
    check("incb_vld",  512'(bus.pkt_vld_out),  512'(1));
    check("incb_data", bus.pkt_data_out,       512'h0029);
    check("incb_port", 512'(bus.pkt_port_out), 512'(1));
    tick();

    // DROP then illegal opcode 9.
    send(512'h4329, 16'h1000, 8'h00);
    send(512'h4329, 16'h9000, 8'h00);
    tick();
    check("drop_vld0", 512'(bus.pkt_vld_out), 512'(0));
    tick();
    check("drop_vld1", 512'(bus.pkt_vld_out), 512'(0));
    check("drop_cnt",  512'(drop_cnt),        512'(2));
    check("bad_cnt",   512'(bad_op_cnt),      512'(1));
    check("ovf_none",  512'(ovf_cnt),         512'(0));

    // Overflow: six back-to-back strobes into a stalled FIFO of depth 4.
    bus.pkt_rdy_in = 1'b0;
    for (int i = 1; i <= 6; i++) send(512'(i), 16'h0000, 8'h00);
    tick();
    check("ovf_cnt",    512'(ovf_cnt),        512'(2));
    check("ovf_drop",   512'(drop_cnt),       512'(2));
    check("ovf_head_v", 512'(bus.pkt_vld_out), 512'(1));
    check("ovf_port",   512'(bus.pkt_port_out), 512'(0));
    bus.pkt_rdy_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_vld",  512'(bus.pkt_vld_out), 512'(1));
      check("drain_data", bus.pkt_data_out,      512'(i));
      tick();
    end
    check("drain_empty", 512'(bus.pkt_vld_out), 512'(0));
    check("drain_hold",  bus.pkt_data_out,      512'(4));
    bus.pkt_rdy_in = 1'b0;

    // Full FIFO: push and pop on the same edge.
    for (int i = 0; i < 4; i++) send(512'('h10 + i), 16'h0000, 8'h00);
    tick();
    check("full_ovf0", 512'(ovf_cnt),     512'(2));
    check("full_head", bus.pkt_data_out,  512'h10);
    bus.pkt_vld_in  = 1'b1;
    bus.pkt_data_in = 512'h14;
    bus.action_in   = 16'h0000;
    tick();
    bus.pkt_vld_in  = 1'b0;
    bus.pkt_rdy_in  = 1'b1;
    tick();
    bus.pkt_rdy_in  = 1'b0;
    check("pp_ovf",  512'(ovf_cnt),       512'(2));
    check("pp_head", bus.pkt_data_out,    512'h11);
    // Occupancy is still 4, so one more push overflows.
    send(512'h15, 16'h0000, 8'h00);
    tick();
    check("pp_full_ovf", 512'(ovf_cnt), 512'(3));
    bus.pkt_rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_drain", bus.pkt_data_out, 512'('h11 + i));
      tick();
    end
    check("pp_empty", 512'(bus.pkt_vld_out), 512'(0));

    // Async reset with one entry queued and one in stage 1.
    bus.pkt_rdy_in = 1'b0;
    send(512'h20, 16'h0200, 8'h00);
    send(512'h21, 16'h0200, 8'h00);
    check("pre_rst_vld", 512'(bus.pkt_vld_out), 512'(1));
    #3;
    reset = 1'b1;
    #1;
    check("arst_vld",  512'(bus.pkt_vld_out),  512'(0));
    check("arst_data", bus.pkt_data_out,       512'(0));
    check("arst_port", 512'(bus.pkt_port_out), 512'(0));
    check("arst_drop", 512'(drop_cnt),         512'(0));
    check("arst_bad",  512'(bad_op_cnt),       512'(0));
    check("arst_ovf",  512'(ovf_cnt),          512'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", 512'(bus.pkt_vld_out), 512'(0));

    // Normal traffic after reset.
    bus.pkt_rdy_in = 1'b1;
    send(512'h4329, 16'h0700, 8'h00);
    tick();
    check("post_vld",  512'(bus.pkt_vld_out),  512'(1));
    check("post_data", bus.pkt_data_out,       512'h4329);
    check("post_port", 512'(bus.pkt_port_out), 512'(7));
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
